// File: rtl/fetch_sequencer.sv
// fetch_sequencer: MIPS IF-stage control.
// Owns the program counter and issues instruction-memory requests. Each
// fetch cycle it arbitrates, in fixed priority order, between a taken-branch
// redirect from MEM, a halt request, a load-use stall from ID and memory wait
// states. It drives the PC update, the IF/ID write enable and the bubble
// (flush) lines for IF/ID, ID/EX and EX/MEM.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PC_Src,
   input  logic [31:0] EX_MEM_NPC,
   input  logic        load_use_hazard,
   input  logic        halt_req,
   input  logic        resume,
   input  logic        imem_ready,
   output logic        imem_req,
   output logic [31:0] pc,
   output logic        if_id_we,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_flush,
   output logic        halted,
   output logic        fetch_err,
   output logic [15:0] redirect_cnt,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // The wait counter is 8 bits wide, so TIMEOUT must be in the range 1..255.
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] pc_r;
   logic [31:0] pc_nxt_s;
   logic [7:0]  wait_cnt_r;
   logic [7:0]  wait_nxt_s;
   logic        fetch_err_r;
   logic        err_set_s;
   logic        redir_inc_s;
   logic        stall_inc_s;
   logic [15:0] redirect_cnt_r;
   logic [15:0] stall_cnt_r;

   // A redirect target is misaligned when either of its two low bits is set.
   function automatic logic misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

   // State, program counter, wait counter and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_BOOT;
         pc_r        <= RESET_PC;
         wait_cnt_r  <= 8'd0;
         fetch_err_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         pc_r        <= pc_nxt_s;
         wait_cnt_r  <= wait_nxt_s;
         fetch_err_r <= fetch_err_r | err_set_s;
      end
   end

   // Saturating event counters: they hold at 16'hFFFF instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_cnt_r <= 16'd0;
         stall_cnt_r    <= 16'd0;
      end else begin
         if (redir_inc_s && (redirect_cnt_r != 16'hFFFF)) begin
            redirect_cnt_r <= redirect_cnt_r + 16'd1;
         end else begin
            redirect_cnt_r <= redirect_cnt_r;
         end
         if (stall_inc_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   // Next-state logic and Mealy pipeline controls, resolved by the fetch priority.
   always_comb begin
      state_nxt_s  = state_r;
      pc_nxt_s     = pc_r;
      wait_nxt_s   = wait_cnt_r;
      err_set_s    = 1'b0;
      redir_inc_s  = 1'b0;
      stall_inc_s  = 1'b0;
      imem_req     = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      halted       = 1'b0;

      case (state_r)
         ST_BOOT: begin
            if_id_flush = 1'b1;
            wait_nxt_s  = 8'd0;
            state_nxt_s = ST_FETCH;
         end

         ST_FETCH: begin
            imem_req = 1'b1;
            if (PC_Src) begin
               // A taken branch overrides everything; any returning fetch data is dropped.
               if_id_flush  = 1'b1;
               id_ex_flush  = 1'b1;
               ex_mem_flush = 1'b1;
               redir_inc_s  = 1'b1;
               wait_nxt_s   = 8'd0;
               if (misaligned(EX_MEM_NPC)) begin
                  err_set_s   = 1'b1;
                  state_nxt_s = ST_HALTED;
               end else begin
                  pc_nxt_s = EX_MEM_NPC;
               end
            end else if (halt_req) begin
               if_id_flush = 1'b1;
               state_nxt_s = ST_HALTED;
            end else if (load_use_hazard) begin
               // IF/ID keeps its contents; the same address is fetched again.
               stall_inc_s = 1'b1;
            end else if (imem_ready) begin
               if_id_we   = 1'b1;
               pc_nxt_s   = pc_r + 32'd4;
               wait_nxt_s = 8'd0;
            end else begin
               // Memory wait state: insert a bubble and count toward the timeout.
               if_id_flush = 1'b1;
               stall_inc_s = 1'b1;
               wait_nxt_s  = wait_cnt_r + 8'd1;
               if ((wait_cnt_r + 8'd1) == TIMEOUT_C) begin
                  err_set_s   = 1'b1;
                  state_nxt_s = ST_HALTED;
               end else begin
                  state_nxt_s = ST_FETCH;
               end
            end
         end

         ST_HALTED: begin
            if_id_flush = 1'b1;
            halted      = 1'b1;
            wait_nxt_s  = 8'd0;
            if (PC_Src) begin
               // Redirects still land while halted so the restart address is correct.
               id_ex_flush  = 1'b1;
               ex_mem_flush = 1'b1;
               redir_inc_s  = 1'b1;
               if (misaligned(EX_MEM_NPC)) begin
                  err_set_s = 1'b1;
               end else begin
                  pc_nxt_s = EX_MEM_NPC;
               end
            end else begin
               pc_nxt_s = pc_r;
            end
            // Once an error is flagged only reset can restart fetching.
            if (resume && !fetch_err_r && !err_set_s) begin
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_HALTED;
            end
         end

         default: begin
            state_nxt_s = ST_BOOT;
         end
      endcase
   end

   assign pc           = pc_r;
   assign fetch_err    = fetch_err_r;
   assign redirect_cnt = redirect_cnt_r;
   assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer. Inputs change 1 ns
// after the rising edge, and outputs are sampled 1 ns after that.
module tb_fetch_sequencer;

   logic        clk;
   logic        rst_n;
   logic        PC_Src;
   logic [31:0] EX_MEM_NPC;
   logic        load_use_hazard;
   logic        halt_req;
   logic        resume;
   logic        imem_ready;
   logic        imem_req;
   logic [31:0] pc;
   logic        if_id_we;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        ex_mem_flush;
   logic        halted;
   logic        fetch_err;
   logic [15:0] redirect_cnt;
   logic [15:0] stall_cnt;

   int checks;
   int failures;

   fetch_sequencer #(
      .RESET_PC (32'h0000_0000),
      .TIMEOUT  (15)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .PC_Src          (PC_Src),
      .EX_MEM_NPC      (EX_MEM_NPC),
      .load_use_hazard (load_use_hazard),
      .halt_req        (halt_req),
      .resume          (resume),
      .imem_ready      (imem_ready),
      .imem_req        (imem_req),
      .pc              (pc),
      .if_id_we        (if_id_we),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_flush    (ex_mem_flush),
      .halted          (halted),
      .fetch_err       (fetch_err),
      .redirect_cnt    (redirect_cnt),
      .stall_cnt       (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   // Apply reset, release it, and leave the bench inside the BOOT cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      settle();
   endtask

   initial begin
      checks          = 0;
      failures        = 0;
      rst_n           = 1'b0;
      PC_Src          = 1'b0;
      EX_MEM_NPC      = 32'h0;
      load_use_hazard = 1'b0;
      halt_req        = 1'b0;
      resume          = 1'b0;
      imem_ready      = 1'b0;

      // ---- reset values ----
      cyc();
      settle();
      chk("rst_pc",        pc,           32'h0);
      chk("rst_req",       imem_req,     32'd0);
      chk("rst_we",        if_id_we,     32'd0);
      chk("rst_ifid_fl",   if_id_flush,  32'd1);
      chk("rst_idex_fl",   id_ex_flush,  32'd0);
      chk("rst_exmem_fl",  ex_mem_flush, 32'd0);
      chk("rst_halted",    halted,       32'd0);
      chk("rst_err",       fetch_err,    32'd0);
      chk("rst_rcnt",      redirect_cnt, 32'd0);
      chk("rst_scnt",      stall_cnt,    32'd0);

      // ---- straight-line fetch: pc 0,0,4,8,C,10 ----
      imem_ready = 1'b1;
      do_reset();
      chk("boot_pc",  pc,       32'h0);
      chk("boot_req", imem_req, 32'd0);
      chk("boot_we",  if_id_we, 32'd0);
      chk("boot_fl",  if_id_flush, 32'd1);
      cyc();
      chk("f1_pc",  pc,       32'h0);
      chk("f1_we",  if_id_we, 32'd1);
      chk("f1_req", imem_req, 32'd1);
      chk("f1_fl",  if_id_flush, 32'd0);
      cyc();
      chk("f2_pc", pc, 32'h4);
      cyc();
      chk("f3_pc", pc, 32'h8);
      cyc();
      chk("f4_pc", pc, 32'hC);
      cyc();
      chk("f5_pc", pc, 32'h10);
      chk("f5_rcnt", redirect_cnt, 32'd0);
      chk("f5_scnt", stall_cnt,    32'd0);

      // ---- taken redirect to 0x40 with imem_ready also high ----
      PC_Src     = 1'b1;
      EX_MEM_NPC = 32'h40;
      settle();
      chk("rd_ifid_fl",  if_id_flush,  32'd1);
      chk("rd_idex_fl",  id_ex_flush,  32'd1);
      chk("rd_exmem_fl", ex_mem_flush, 32'd1);
      chk("rd_we",       if_id_we,     32'd0);
      cyc();
      PC_Src = 1'b0;
      settle();
      chk("rd_pc",   pc,           32'h40);
      chk("rd_rcnt", redirect_cnt, 32'd1);
      chk("rd_we2",  if_id_we,     32'd1);

      // ---- load-use stall for two cycles at 0x40 ----
      load_use_hazard = 1'b1;
      settle();
      chk("lu_we",    if_id_we,     32'd0);
      chk("lu_fl",    if_id_flush,  32'd0);
      chk("lu_fl2",   id_ex_flush,  32'd0);
      chk("lu_fl3",   ex_mem_flush, 32'd0);
      cyc();
      chk("lu_pc1", pc, 32'h40);
      cyc();
      load_use_hazard = 1'b0;
      settle();
      chk("lu_pc2",  pc,        32'h40);
      chk("lu_scnt", stall_cnt, 32'd2);
      chk("lu_we2",  if_id_we,  32'd1);
      cyc();
      chk("lu_adv", pc, 32'h44);

      // ---- three wait states, then data (clears the wait counter) ----
      imem_ready = 1'b0;
      settle();
      chk("ws_fl", if_id_flush, 32'd1);
      chk("ws_we", if_id_we,    32'd0);
      cyc();
      cyc();
      cyc();
      imem_ready = 1'b1;
      settle();
      chk("ws_pc",   pc,        32'h44);
      chk("ws_scnt", stall_cnt, 32'd5);
      cyc();
      chk("ws_adv", pc, 32'h48);

      // ---- timeout: 15 consecutive wait cycles ----
      imem_ready = 1'b0;
      for (int i = 0; i < 14; i++) cyc();
      chk("to_err14",  fetch_err, 32'd0);
      chk("to_halt14", halted,    32'd0);
      chk("to_req14",  imem_req,  32'd1);
      cyc();
      chk("to_err",  fetch_err, 32'd1);
      chk("to_halt", halted,    32'd1);
      chk("to_req",  imem_req,  32'd0);
      chk("to_pc",   pc,        32'h48);
      chk("to_scnt", stall_cnt, 32'd20);

      // ---- resume ignored while the error is set ----
      resume     = 1'b1;
      imem_ready = 1'b1;
      cyc();
      cyc();
      chk("to_res_halt", halted,   32'd1);
      chk("to_res_req",  imem_req, 32'd0);
      chk("to_res_pc",   pc,       32'h48);
      resume = 1'b0;

      // ---- asynchronous reset mid-operation ----
      rst_n = 1'b0;
      settle();
      chk("ar_pc",   pc,           32'h0);
      chk("ar_err",  fetch_err,    32'd0);
      chk("ar_halt", halted,       32'd0);
      chk("ar_rcnt", redirect_cnt, 32'd0);
      chk("ar_scnt", stall_cnt,    32'd0);
      chk("ar_req",  imem_req,     32'd0);

      // ---- halt at 0x10, redirect while halted, resume ----
      do_reset();
      for (int i = 0; i < 5; i++) cyc();
      chk("h_pc0", pc, 32'h10);
      halt_req = 1'b1;
      settle();
      chk("h_fl", if_id_flush, 32'd1);
      chk("h_we", if_id_we,    32'd0);
      cyc();
      halt_req = 1'b0;
      settle();
      chk("h_halt", halted,   32'd1);
      chk("h_req",  imem_req, 32'd0);
      chk("h_pc",   pc,       32'h10);
      PC_Src     = 1'b1;
      EX_MEM_NPC = 32'h80;
      settle();
      chk("hr_idex_fl",  id_ex_flush,  32'd1);
      chk("hr_exmem_fl", ex_mem_flush, 32'd1);
      cyc();
      PC_Src = 1'b0;
      settle();
      chk("hr_pc",   pc,           32'h80);
      chk("hr_halt", halted,       32'd1);
      chk("hr_rcnt", redirect_cnt, 32'd1);
      resume = 1'b1;
      cyc();
      resume = 1'b0;
      settle();
      chk("hres_halt", halted,   32'd0);
      chk("hres_req",  imem_req, 32'd1);
      chk("hres_pc",   pc,       32'h80);
      chk("hres_we",   if_id_we, 32'd1);
      cyc();
      chk("hres_adv", pc, 32'h84);

      // ---- misaligned redirect target ----
      PC_Src     = 1'b1;
      EX_MEM_NPC = 32'h42;
      cyc();
      PC_Src = 1'b0;
      settle();
      chk("mis_err",  fetch_err,    32'd1);
      chk("mis_pc",   pc,           32'h84);
      chk("mis_halt", halted,       32'd1);
      chk("mis_rcnt", redirect_cnt, 32'd2);

      // ---- PC wraps from FFFF_FFFC to 0 ----
      do_reset();
      cyc();
      PC_Src     = 1'b1;
      EX_MEM_NPC = 32'hFFFF_FFFC;
      cyc();
      PC_Src = 1'b0;
      settle();
      chk("wr_pc",  pc,        32'hFFFF_FFFC);
      chk("wr_we",  if_id_we,  32'd1);
      chk("wr_err", fetch_err, 32'd0);
      cyc();
      chk("wr_wrap", pc, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
